// File: rtl/alu_mul_sequencer.sv
// Shift-and-add multiplier controller that borrows the shared ALU adder to
// produce the low WIDTH bits of a WIDTH x WIDTH product, one multiplier bit per cycle.
module alu_mul_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             Start_i,
    input  logic [WIDTH-1:0] Multiplicand_i,
    input  logic [WIDTH-1:0] Multiplier_i,
    input  logic [WIDTH-1:0] ALU_Result_i,
    output logic [3:0]       ALU_Operation_o,
    output logic [WIDTH-1:0] ALU_A_o,
    output logic [WIDTH-1:0] ALU_B_o,
    output logic             ALU_Owner_o,
    output logic             Busy_o,
    output logic             Done_o,
    output logic [WIDTH-1:0] Result_o,
    output logic             Zero_o
);
    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] ITER = 2'd1;
    localparam logic [1:0] DONE = 2'd2;

    logic [1:0]       state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] count;
    logic [WIDTH-1:0] acc_next;
    logic             last;

    // The ALU sum is only taken when the current multiplier bit is set.
    always_comb begin
        acc_next = mplier[0] ? ALU_Result_i : acc;
        last     = (count == CNT_W'(WIDTH - 1)) || ((mplier >> 1) == '0);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state    <= IDLE;
            acc      <= '0;
            mcand    <= '0;
            mplier   <= '0;
            count    <= '0;
            Result_o <= '0;
            Zero_o   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (Start_i) begin
                        mcand  <= Multiplicand_i;
                        mplier <= Multiplier_i;
                        acc    <= '0;
                        count  <= '0;
                        state  <= ITER;
                    end
                end
                ITER: begin
                    acc    <= acc_next;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    // Early exit once no set multiplier bits remain.
                    if (last) begin
                        state    <= DONE;
                        Result_o <= acc_next;
                        Zero_o   <= (acc_next == '0);
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

    assign ALU_Operation_o = 4'b0000;
    assign ALU_Owner_o     = (state == ITER);
    assign ALU_A_o         = ALU_Owner_o ? acc : '0;
    assign ALU_B_o         = ALU_Owner_o ? mcand : '0;
    assign Busy_o          = (state != IDLE);
    assign Done_o          = (state == DONE);
endmodule
